// File: rtl/prng_xoshiro128_jumpable_if.sv
// Bus bundle for the jumpable xoshiro128 generator: control, seed and
// jump request inputs plus the registered state/result outputs.
interface prng_xoshiro128_jumpable_if;
  logic        i_cg;
  logic        i_seedValid;
  logic [31:0] i_seedS0;
  logic [31:0] i_seedS1;
  logic [31:0] i_seedS2;
  logic [31:0] i_seedS3;
  logic        i_jumpReq;
  logic        i_jumpLong;
  logic        o_jumpBusy;
  logic        o_jumpDone;
  logic [31:0] o_s0;
  logic [31:0] o_s1;
  logic [31:0] o_s2;
  logic [31:0] o_s3;
  logic [31:0] o_result;
  logic        o_resultValid;

  modport master (
    output i_cg, i_seedValid, i_seedS0, i_seedS1, i_seedS2, i_seedS3,
           i_jumpReq, i_jumpLong,
    input  o_jumpBusy, o_jumpDone, o_s0, o_s1, o_s2, o_s3,
           o_result, o_resultValid
  );

  modport slave (
    input  i_cg, i_seedValid, i_seedS0, i_seedS1, i_seedS2, i_seedS3,
           i_jumpReq, i_jumpLong,
    output o_jumpBusy, o_jumpDone, o_s0, o_s1, o_s2, o_s3,
           o_result, o_resultValid
  );
endinterface

// File: rtl/prng_xoshiro128_jumpable.sv
// xoshiro128 generator with selectable scrambler (+, ++, **) and a
// 128-cycle hardware sequencer for jump() / long_jump().
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | seed load, jump start, or one next() per cycle when i_cg
// ST_JUMP | step k=0..127 through the jump polynomial; k=127 loads acc
module prng_xoshiro128_jumpable #(
  parameter int          SCRAMBLER = 0,
  parameter logic [31:0] RESET_S0  = 32'h00000001,
  parameter logic [31:0] RESET_S1  = 32'h00000002,
  parameter logic [31:0] RESET_S2  = 32'h00000003,
  parameter logic [31:0] RESET_S3  = 32'h00000004
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  prng_xoshiro128_jumpable_if.slave  bus
);

  typedef enum logic {ST_IDLE, ST_JUMP} state_t;

  // Word 0 sits in the low 32 bits so that bit k of the vector is bit k%32 of word k/32.
  localparam logic [127:0] JUMP_C = {32'h77f2db5b, 32'h6fa035c3, 32'hf542d2d3, 32'h8764000b};
  localparam logic [127:0] LONG_C = {32'h1c580662, 32'hccf5a0ef, 32'h0b6f099f, 32'hb523952e};

  state_t       state, state_nxt;
  logic [31:0]  s0, s1, s2, s3;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] acc, acc_nxt;
  logic [6:0]   step;
  logic         is_long;
  logic [31:0]  result;
  logic         result_valid;
  logic         jump_done;
  logic [31:0]  scr;

  logic load_seed, advance, start_jump, jump_step, jump_last;
  logic jump_bit;

  function automatic logic [31:0] rotl7(input logic [31:0] x);
    return {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] rotl11(input logic [31:0] x);
    return {x[20:0], x[31:21]};
  endfunction

  // One xoshiro128 next() applied to the current registered state.
  always_comb begin
    logic [31:0] t, a2, a3;
    t  = s1 << 9;
    a2 = s2 ^ s0;
    a3 = s3 ^ s1;
    n1 = s1 ^ a2;
    n0 = s0 ^ a3;
    n2 = a2 ^ t;
    n3 = rotl11(a3);
  end

  // Output scrambler on the pre-advance state; multiplies by 5 and 9 are shift-adds.
  always_comb begin
    logic [31:0] sum, m5, r;
    sum = s0 + s3;
    m5  = (s1 << 2) + s1;
    r   = rotl7(m5);
    case (SCRAMBLER)
      1:       scr = rotl7(sum) + s0;
      2:       scr = (r << 3) + r;
      default: scr = sum;
    endcase
  end

  assign jump_bit = is_long ? LONG_C[step] : JUMP_C[step];
  assign acc_nxt  = jump_bit ? (acc ^ {s0, s1, s2, s3}) : acc;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and datapath strobes; seed load beats jump request beats advance.
  always_comb begin
    state_nxt  = state;
    load_seed  = 1'b0;
    advance    = 1'b0;
    start_jump = 1'b0;
    jump_step  = 1'b0;
    jump_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.i_seedValid) begin
          load_seed = 1'b1;
        end else if (bus.i_jumpReq) begin
          start_jump = 1'b1;
          state_nxt  = ST_JUMP;
        end else if (bus.i_cg) begin
          advance = 1'b1;
        end
      end
      ST_JUMP: begin
        if (bus.i_seedValid) begin
          load_seed = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          jump_step = 1'b1;
          if (step == 7'd127) begin
            jump_last = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Generator state: seed load, normal advance, jump stepping, final accumulator load.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s0 <= RESET_S0;
      s1 <= RESET_S1;
      s2 <= RESET_S2;
      s3 <= RESET_S3;
    end else if (load_seed) begin
      s0 <= bus.i_seedS0;
      s1 <= bus.i_seedS1;
      s2 <= bus.i_seedS2;
      s3 <= bus.i_seedS3;
    end else if (jump_last) begin
      {s0, s1, s2, s3} <= acc_nxt;
    end else if (advance || jump_step) begin
      s0 <= n0;
      s1 <= n1;
      s2 <= n2;
      s3 <= n3;
    end
  end

  // Jump sequencer bookkeeping: accumulator, step counter and latched jump kind.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      acc     <= '0;
      step    <= '0;
      is_long <= 1'b0;
    end else if (start_jump) begin
      acc     <= '0;
      step    <= '0;
      is_long <= bus.i_jumpLong;
    end else if (jump_step) begin
      acc  <= acc_nxt;
      step <= step + 7'd1;
    end
  end

  // Registered result, its valid flag and the jump-complete pulse.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      result       <= '0;
      result_valid <= 1'b0;
      jump_done    <= 1'b0;
    end else begin
      if (advance) result <= scr;
      result_valid <= advance;
      jump_done    <= jump_last;
    end
  end

  assign bus.o_s0          = s0;
  assign bus.o_s1          = s1;
  assign bus.o_s2          = s2;
  assign bus.o_s3          = s3;
  assign bus.o_result      = result;
  assign bus.o_resultValid = result_valid;
  assign bus.o_jumpBusy    = (state == ST_JUMP);
  assign bus.o_jumpDone    = jump_done;

endmodule
